// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM
// states and the quotient written on a divide by zero.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    // Sliced down to WIDTH by the user; wide enough for any sane operand size.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide, sharing a single 2*WIDTH accumulator.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0] operand;
    logic             div_mode;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, operand});
        div_diff  = div_shift[WIDTH-1:0] - operand;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc      <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            operand  <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
        end else if (step) begin
            if (div_mode) begin
                if (div_ge)
                    acc <= {div_diff, acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, iteration counter, sign handling and
// the architectural HI/LO registers around the unsigned iterative datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             state;
    logic [CW-1:0]      count;
    logic               neg_q;
    logic               neg_r;
    logic               div_mode;
    logic               div_zero;
    logic [WIDTH-1:0]   dividend;

    logic               signed_op;
    logic               div_op;
    logic               md_op;
    logic               accept;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
        md_op     = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        accept    = (state == IDLE) && start && md_op;
        a_mag     = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        b_mag     = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    // Divide by zero bypasses the datapath result and reports the raw dividend.
    always_comb begin
        quot   = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        prod   = neg_q ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_mode) begin
            if (div_zero) begin
                fix_lo = DIV0_QUOTIENT[WIDTH-1:0];
                fix_hi = dividend;
            end else begin
                fix_lo = neg_q ? -quot : quot;
                fix_hi = neg_r ? -rem : rem;
            end
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .load   (accept),
        .step   (state == RUN),
        .is_div (div_op),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    // Starts arriving while busy are dropped; control is expected to stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_mode <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        count    <= '0;
                        busy     <= 1'b1;
                        neg_q    <= signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_r    <= signed_op && div_op && rs_data[WIDTH-1];
                        div_mode <= div_op;
                        div_zero <= div_op && (rt_data == '0);
                        dividend <= rs_data;
                    end else if (start && (op == OP_MTHI)) begin
                        hi <= rs_data;
                    end else if (start && (op == OP_MTLO)) begin
                        lo <= rs_data;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops,
// compared against an arithmetic HI/LO model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task check_output(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Architectural meaning of each op, using wide signed/unsigned arithmetic.
    task model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin
                p = sa * sb;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd2, 3'd3: begin
                if (b == '0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else if (o == 3'd2) begin
                    p = sa / sb;
                    exp_lo = p[31:0];
                    p = sa % sb;
                    exp_hi = p[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one mult/div from the current negedge and follow it to completion.
    task apply_stimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit inject, input bit chain);
        int           n;
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        old_hi  = exp_hi;
        old_lo  = exp_lo;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        model_apply(o, a, b);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            start   = inject && (n == 5 || n == 6 || n == 33);
            op      = (n == 5) ? 3'd5 : ((n == 6) ? 3'd1 : 3'd4);
            rs_data = (n == 5) ? 32'h1 : $urandom;
            rt_data = $urandom;
            if (n == 16) begin
                check_output({tag, "_hold_hi"}, hi, old_hi);
                check_output({tag, "_hold_lo"}, lo, old_lo);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_output({tag, "_busy_cycles"}, 32'(n), 32'(W + 1));
        check_output({tag, "_done"}, {31'b0, done}, 32'd1);
        check_output({tag, "_hi"}, hi, exp_hi);
        check_output({tag, "_lo"}, lo, exp_lo);
        if (!chain) begin
            @(negedge clk);
            check_output({tag, "_done_drop"}, {31'b0, done}, 32'd0);
            check_output({tag, "_hi_keep"}, hi, exp_hi);
        end
    endtask

    task single_cycle(input logic [2:0] o, input logic [W-1:0] a, input string tag);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        model_apply(o, a, 32'h0);
        check_output({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check_output({tag, "_done"}, {31'b0, done}, 32'd0);
        check_output({tag, "_hi"}, hi, exp_hi);
        check_output({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int           pulses;
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = '0;
        rt_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_hi", hi, 32'd0);
        check_output("rst_lo", lo, 32'd0);

        apply_stimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_ff", 1'b0, 1'b0);
        check_output("multu_ff_hi_const", hi, 32'hFFFF_FFFE);
        check_output("multu_ff_lo_const", lo, 32'h0000_0001);
        apply_stimulus(3'd0, -32'sd3, 32'd7, "mult_m3x7", 1'b0, 1'b0);
        check_output("mult_m3x7_lo_const", lo, 32'hFFFF_FFEB);
        apply_stimulus(3'd2, -32'sd7, 32'd2, "div_m7d2", 1'b0, 1'b0);
        check_output("div_m7d2_lo_const", lo, 32'hFFFF_FFFD);
        check_output("div_m7d2_hi_const", hi, 32'hFFFF_FFFF);
        apply_stimulus(3'd3, 32'd100, 32'd7, "divu_100d7", 1'b0, 1'b0);
        check_output("divu_100d7_lo_const", lo, 32'd14);
        apply_stimulus(3'd3, 32'h64, 32'd0, "divu_by0", 1'b0, 1'b0);
        check_output("divu_by0_hi_const", hi, 32'h64);
        apply_stimulus(3'd2, 32'd0, 32'd0, "div_0by0", 1'b0, 1'b0);
        apply_stimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0);
        check_output("div_ovf_lo_const", lo, 32'h8000_0000);

        single_cycle(3'd4, 32'h1234_5678, "mthi");
        single_cycle(3'd5, 32'hCAFE_BABE, "mtlo");
        single_cycle(3'd6, 32'hDEAD_BEEF, "rsvd6");
        single_cycle(3'd7, 32'hBEEF_DEAD, "rsvd7");

        apply_stimulus(3'd3, 32'd1000, 32'd33, "divu_busy_ign", 1'b1, 1'b0);
        check_output("divu_busy_ign_lo_const", lo, 32'd30);

        apply_stimulus(3'd1, 32'h0001_0000, 32'h0003_0000, "chain_a", 1'b0, 1'b1);
        apply_stimulus(3'd2, 32'hFFFF_FF00, 32'd16, "chain_b", 1'b0, 1'b0);

        start   = 1'b1;
        op      = 3'd0;
        rs_data = -32'sd5;
        rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check_output("midrst_busy", {31'b0, busy}, 32'd0);
        check_output("midrst_done", {31'b0, done}, 32'd0);
        check_output("midrst_hi", hi, 32'd0);
        check_output("midrst_lo", lo, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check_output("midrst_no_done", 32'(pulses), 32'd0);
        apply_stimulus(3'd0, -32'sd5, 32'd9, "after_rst", 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (ro <= 3'd3)
                apply_stimulus(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 1'b0, bit'($urandom_range(0, 1)));
            else
                single_cycle(ro, ra, $sformatf("rand%0d_op%0d", i, ro));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
